// File: rtl/axi4_lite_pkg.sv
// Shared state encoding, response codes and default widths for the AXI4-Lite master.
package axi4_lite_pkg;

    localparam int unsigned ADDR_WIDTH_DEF     = 4;
    localparam int unsigned DATA_WIDTH_DEF     = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R
    } master_state_e;

endpackage

// File: rtl/axi4_lite_master_wdog.sv
// Transaction watchdog for axi4_lite_master; only built when AXI_MASTER_TIMEOUT_EN is defined.
`ifdef AXI_MASTER_TIMEOUT_EN
module axi4_lite_master_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic busy_i,
    output logic timeout_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating count of busy cycles since the last accepted command.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (busy_i && (cnt_q != CNT_W'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_o <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (clear_i) begin
                timeout_o <= 1'b0;
            end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator with one outstanding transaction.
// Optional watchdog flag enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  transfer,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            resp,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    output logic                  RREADY
);
    master_state_e state_q;

    logic accept_c;
    logic aw_ok_c;
    logic w_ok_c;

    // A zero-length watchdog would give a zero-width counter.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    assign accept_c = transfer && ready;
    // A channel is complete once its VALID has dropped or it handshakes this cycle.
    assign aw_ok_c  = !AWVALID || AWREADY;
    assign w_ok_c   = !WVALID || WREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            rdata   <= '0;
            resp    <= RESP_OKAY;
            AWADDR  <= '0;
            AWVALID <= 1'b0;
            WDATA   <= '0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            ARADDR  <= '0;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        ready <= 1'b0;
                        if (write) begin
                            state_q <= WR_AW_W;
                            AWADDR  <= addr;
                            WDATA   <= wdata;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                        end else begin
                            state_q <= RD_AR;
                            ARADDR  <= addr;
                            ARVALID <= 1'b1;
                        end
                    end
                end
                WR_AW_W: begin
                    if (AWVALID && AWREADY) AWVALID <= 1'b0;
                    if (WVALID && WREADY)   WVALID  <= 1'b0;
                    if (aw_ok_c && w_ok_c) begin
                        state_q <= WR_B;
                        BREADY  <= 1'b1;
                    end
                end
                WR_B: begin
                    if (BVALID) begin
                        state_q <= IDLE;
                        BREADY  <= 1'b0;
                        resp    <= BRESP;
                        done    <= 1'b1;
                        ready   <= 1'b1;
                    end
                end
                RD_AR: begin
                    if (ARREADY) begin
                        state_q <= RD_R;
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                    end
                end
                RD_R: begin
                    if (RVALID) begin
                        state_q <= IDLE;
                        RREADY  <= 1'b0;
                        rdata   <= RDATA;
                        resp    <= RESP_OKAY;
                        done    <= 1'b1;
                        ready   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    axi4_lite_master_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (ACLK),
        .rst_i    (ARESET),
        .clear_i  (accept_c),
        .busy_i   (state_q != IDLE),
        .timeout_o(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a behavioural 4-register AXI4-Lite slave.
module tb_axi4_lite_master;
    import axi4_lite_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          transfer, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready, done, timeout;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [DW-1:0] WDATA, RDATA;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]    BRESP;

    always #5 ACLK = ~ACLK;

    axi4_lite_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
        .resp(resp), .timeout(timeout),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
    );

    // ---------------- slave model ----------------
    int         aw_dly = 0, w_dly = 0, ar_dly = 0;
    bit         ar_block = 1'b0, b_hold = 1'b0;
    logic [1:0] bresp_cfg = RESP_OKAY;
    int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic [DW-1:0] regs [4];
    logic          aw_got, w_got;
    logic [AW-1:0] aw_a;
    logic [DW-1:0] w_d;

    assign AWREADY = AWVALID && (aw_cnt >= aw_dly);
    assign WREADY  = WVALID && (w_cnt >= w_dly);
    assign ARREADY = ARVALID && !ar_block && (ar_cnt >= ar_dly);

    always @(posedge ACLK) begin : slave
        logic          aw_n, w_n;
        logic [AW-1:0] a_n;
        logic [DW-1:0] d_n;
        aw_n = aw_got || (AWVALID && AWREADY);
        w_n  = w_got || (WVALID && WREADY);
        a_n  = (AWVALID && AWREADY) ? AWADDR : aw_a;
        d_n  = (WVALID && WREADY) ? WDATA : w_d;
        if (ARESET) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; aw_a <= '0; w_d <= '0;
            BVALID <= 1'b0; BRESP <= RESP_OKAY; RVALID <= 1'b0; RDATA <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
        end else begin
            aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
            if (BVALID && BREADY) BVALID <= 1'b0;
            if (RVALID && RREADY) RVALID <= 1'b0;
            if (aw_n && w_n && !BVALID && !b_hold) begin
                regs[a_n[3:2]] <= d_n;
                BVALID <= 1'b1;
                BRESP  <= bresp_cfg;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                aw_got <= aw_n; w_got <= w_n; aw_a <= a_n; w_d <= d_n;
            end
            if (ARVALID && ARREADY) begin
                RVALID <= 1'b1;
                RDATA  <= regs[ARADDR[3:2]];
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // VALID must stay high with a stable payload until its handshake.
    logic          pv_aw = 1'b0, pv_w = 1'b0, pv_ar = 1'b0, p_rst = 1'b1;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    always @(negedge ACLK) begin
        #2;
        if (pv_aw && !p_rst) check("aw_hold", {AWVALID, AWADDR}, {1'b1, p_awaddr});
        if (pv_w && !p_rst)  check("w_hold", {WVALID, WDATA}, {1'b1, p_wdata});
        if (pv_ar && !p_rst) check("ar_hold", {ARVALID, ARADDR}, {1'b1, p_araddr});
        pv_aw = AWVALID && !AWREADY; p_awaddr = AWADDR;
        pv_w  = WVALID && !WREADY;   p_wdata  = WDATA;
        pv_ar = ARVALID && !ARREADY; p_araddr = ARADDR;
        p_rst = ARESET;
    end

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    bresp;
        int            awd, wd, ard;
        int            lat;
        logic [1:0]    resp;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t vecs [9];
    logic [3:0] skew_exp [6] = '{4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0010, 4'b0001};

    // Issue one command from a negedge and wait for done; returns cycles and ready-cycles seen.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output int hs);
        transfer = 1'b1; write = wr; addr = a; wdata = d;
        @(posedge ACLK); #1;
        transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        lat = 0; hs = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge ACLK);
            lat++;
            if (BREADY || RREADY) hs++;
            if (done) break;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge ACLK);
            n++;
            if (done) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, hs, n;
        transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;

        vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, RESP_OKAY,   0, 0, 0, 3, RESP_OKAY,   32'h0};
        vecs[1] = '{1'b0, 4'h4, 32'h0,        RESP_OKAY,   0, 0, 0, 3, RESP_OKAY,   32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'hC, 32'h12345678, RESP_OKAY,   0, 0, 0, 3, RESP_OKAY,   32'hDEADBEEF};
        vecs[3] = '{1'b0, 4'hC, 32'h0,        RESP_OKAY,   0, 0, 0, 3, RESP_OKAY,   32'h12345678};
        vecs[4] = '{1'b1, 4'h8, 32'hA5A50F0F, RESP_SLVERR, 0, 0, 0, 3, RESP_SLVERR, 32'h12345678};
        vecs[5] = '{1'b0, 4'h8, 32'h0,        RESP_OKAY,   0, 0, 0, 3, RESP_OKAY,   32'hA5A50F0F};
        vecs[6] = '{1'b0, 4'hC, 32'h0,        RESP_OKAY,   0, 0, 2, 5, RESP_OKAY,   32'h12345678};
        vecs[7] = '{1'b1, 4'h0, 32'h0BADF00D, RESP_OKAY,   1, 0, 0, 4, RESP_OKAY,   32'h12345678};
        vecs[8] = '{1'b0, 4'h0, 32'h0,        RESP_OKAY,   0, 0, 0, 3, RESP_OKAY,   32'h0BADF00D};

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_ready", ready, 1'b1);
        check("rst_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, done, timeout}, 7'b0);
        check("rst_data", {AWADDR, WDATA, ARADDR, rdata, resp}, '0);
        ARESET = 1'b0;
        @(negedge ACLK);

        // Table: back-to-back commands, each issued in the previous done cycle
        for (int i = 0; i < 9; i++) begin
            aw_dly = vecs[i].awd; w_dly = vecs[i].wd; ar_dly = vecs[i].ard;
            bresp_cfg = vecs[i].bresp;
            run_cmd(vecs[i].wr, vecs[i].a, vecs[i].d, lat, hs);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_resp", i), resp, vecs[i].resp);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            check($sformatf("v%0d_resp_rdy_cycles", i), hs, 1);
            check($sformatf("v%0d_ready_at_done", i), ready, 1'b1);
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; bresp_cfg = RESP_OKAY;

        // Skewed write: W handshakes after 1 cycle, AW after 3
        aw_dly = 3; w_dly = 1;
        transfer = 1'b1; write = 1'b1; addr = 4'h4; wdata = 32'hFEEDFACE;
        @(posedge ACLK); #1;
        transfer = 1'b0; write = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge ACLK);
            check($sformatf("skew_c%0d", k + 1), {AWVALID, WVALID, BREADY, done}, skew_exp[k]);
        end
        aw_dly = 0; w_dly = 0;

        // Transfer while busy is ignored
        ar_dly = 3;
        transfer = 1'b1; write = 1'b0; addr = 4'hC;
        @(posedge ACLK); #1;
        write = 1'b1; addr = 4'h4; wdata = 32'hFFFFFFFF;
        repeat (3) @(posedge ACLK);
        #1 transfer = 1'b0; write = 1'b0;
        wait_done(n);
        check("busy_done", done, 1'b1);
        check("busy_rdata", rdata, 32'h12345678);
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            check($sformatf("busy_idle_c%0d", k), {AWVALID, WVALID, ARVALID, done, ready}, 5'b00001);
        end
        ar_dly = 0;
        run_cmd(1'b0, 4'h4, 32'h0, lat, hs);
        check("busy_reg1", rdata, 32'hFEEDFACE);

        // Reset while waiting in WR_B
        b_hold = 1'b1;
        transfer = 1'b1; write = 1'b1; addr = 4'h0; wdata = 32'h11111111;
        @(posedge ACLK); #1;
        transfer = 1'b0; write = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge ACLK);
            if (BREADY) break;
        end
        check("wrb_reached", BREADY, 1'b1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mid_rst_ctrl", {AWVALID, WVALID, BREADY, ARVALID, RREADY, done, ready}, 7'b0000001);
        check("mid_rst_rdata", rdata, 32'h0);
        ARESET = 1'b0; b_hold = 1'b0;
        run_cmd(1'b0, 4'h0, 32'h0, lat, hs);
        check("post_rst_lat", lat, 3);
        check("post_rst_rdata", rdata, 32'h0);

        // Watchdog: AR never accepted, then released
        run_cmd(1'b1, 4'h4, 32'h5A5A5A5A, lat, hs);
        check("to_prep_lat", lat, 3);
        ar_block = 1'b1;
        transfer = 1'b1; write = 1'b0; addr = 4'h4;
        @(posedge ACLK); #1;
        transfer = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge ACLK);
            if (k == 8) check("to_before_limit", timeout, 1'b0);
            if (k == 9) begin
                check("to_at_limit", timeout, EXP_TO);
                check("to_arvalid_held", ARVALID, 1'b1);
            end
        end
        ar_block = 1'b0;
        wait_done(n);
        check("to_done", done, 1'b1);
        check("to_rdata", rdata, 32'h5A5A5A5A);
        check("to_sticky", timeout, EXP_TO);
        run_cmd(1'b1, 4'h8, 32'h0, lat, hs);
        check("to_cleared", timeout, 1'b0);
        check("to_next_lat", lat, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
